// File: rtl/Isa.sv
// Shared ISA types and fetch-stage defaults used by the fetch pipeline.
package Isa;

    localparam int ALU_W             = 16;
    localparam int ADDR_W            = 8;
    localparam int RESET_PC_DEFAULT  = 0;
    localparam int BUF_DEPTH_DEFAULT = 2;

    typedef logic [ALU_W-1:0] AluPacket;

    // One buffered fetch result at the default address width.
    typedef struct packed {
        AluPacket          instr;
        logic [ADDR_W-1:0] pc;
    } FetchEntry;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOLD,
        ST_FLUSH
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer with synchronous clear; head entry is presented combinationally.
module fetch_fifo #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // NOTE: storage is not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    push_when_full_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !clear_i && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, credit-based RAM read issue, epoch-tagged response capture,
// and a valid/ready output buffer flushed on redirect.
module instr_fetch
    import Isa::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter int                    DATA_WIDTH = ALU_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    BUF_DEPTH  = BUF_DEPTH_DEFAULT
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    output logic                  o_mem_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam int OCC_W   = CNT_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q;
    logic                  inflight_q, inflight_epoch_q, epoch_q;
    logic [CNT_W-1:0]      count;
    logic [ENTRY_W-1:0]    head;
    logic [OCC_W-1:0]      occupancy;
    logic                  issue, push, pop;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (!i_enable) state_d = ST_HOLD;
            ST_HOLD:  if (i_enable)  state_d = ST_RUN;
            ST_FLUSH: state_d = i_enable ? ST_RUN : ST_HOLD;
            default:  state_d = ST_RUN;
        endcase
        if (i_redirect) state_d = ST_FLUSH;
    end

    assign o_valid = (count != '0);
    assign pop     = o_valid && i_ready;
    // Stale-epoch responses and anything landing in the redirect cycle are dropped.
    assign push    = inflight_q && (inflight_epoch_q == epoch_q) && !i_redirect;

    // Credit: buffered words plus the outstanding read, less the one leaving now.
    always_comb begin
        occupancy = OCC_W'(count) + OCC_W'(inflight_q);
        if (pop) occupancy = occupancy - OCC_W'(1);
        issue = i_reset && (state_d == ST_RUN) && (occupancy < OCC_W'(BUF_DEPTH));
        pc_d  = pc_q;
        if (i_redirect)  pc_d = i_redirect_pc;
        else if (issue)  pc_d = pc_q + ADDR_WIDTH'(1);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q          <= ST_RUN;
            pc_q             <= RESET_PC;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_epoch_q <= 1'b0;
            epoch_q          <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q    <= pc_q;
                inflight_epoch_q <= epoch_q;
            end
            if (i_redirect) epoch_q <= ~epoch_q;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (i_clock),
        .rst_n   (i_reset),
        .clear_i (i_redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({i_mem_rdata, inflight_pc_q}),
        .count_o (count),
        .head_o  (head)
    );

    assign o_mem_en   = issue;
    assign o_mem_addr = pc_q;
    assign o_instr    = o_valid ? head[ADDR_WIDTH +: DATA_WIDTH] : '0;
    assign o_pc       = o_valid ? head[0 +: ADDR_WIDTH] : '0;

endmodule
